// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory port, redirect port and the
// valid/ready instruction stream toward decode.
interface fetch_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             mem_req;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_data;
    logic             redirect;
    logic [WIDTH-1:0] redirect_addr;
    logic             redirect_misaligned;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_inst;
    logic [WIDTH-1:0] out_pc;

    modport master (
        output mem_req, mem_addr, redirect_misaligned, out_valid, out_inst, out_pc,
        input  mem_data, redirect, redirect_addr, out_ready
    );

    modport slave (
        input  mem_req, mem_addr, redirect_misaligned, out_valid, out_inst, out_pc,
        output mem_data, redirect, redirect_addr, out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues word reads and buffers
// returned words in a prefetch FIFO. Define FETCH_UNIT_PERF_EN for perf counters.
module fetch_unit #(
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic        clk,
    input  logic        rst,
`ifdef FETCH_UNIT_PERF_EN
    output logic [31:0] perf_delivered,
    output logic [31:0] perf_flushed,
`endif
    fetch_unit_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0]  PTR_ONE = 1;
    localparam logic [AW:0]    CNT_ONE = 1;
    localparam logic [AW+1:0]  DEPTH_W = (AW+2)'(DEPTH);
    localparam logic [WIDTH-1:0] PC_STEP = 4;

    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] infl_pc;
    logic             infl;
    logic [WIDTH-1:0] pc_mem   [DEPTH];
    logic [WIDTH-1:0] inst_mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;

    logic [AW+1:0]    occupancy;
    logic [WIDTH-1:0] redirect_aligned;
    logic             push;
    logic             pop;

    // Credits count in-flight words too, so a returning word always has a slot.
    always_comb begin
        occupancy        = {1'b0, count} + {{(AW+1){1'b0}}, infl};
        redirect_aligned = {bus.redirect_addr[WIDTH-1:2], 2'b00};

        bus.mem_req             = !rst && (bus.redirect || (occupancy < DEPTH_W));
        bus.mem_addr            = bus.redirect ? redirect_aligned : fetch_pc;
        bus.redirect_misaligned = !rst && bus.redirect && (|bus.redirect_addr[1:0]);
        bus.out_valid           = !rst && (count != '0) && !bus.redirect;
        bus.out_inst            = inst_mem[rd_ptr];
        bus.out_pc              = pc_mem[rd_ptr];

        push = !rst && infl && !bus.redirect;
        pop  = bus.out_valid && bus.out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            infl     <= 1'b0;
            infl_pc  <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else if (bus.redirect) begin
            fetch_pc <= redirect_aligned + PC_STEP;
            infl     <= 1'b1;
            infl_pc  <= redirect_aligned;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (bus.mem_req) begin
                fetch_pc <= fetch_pc + PC_STEP;
                infl     <= 1'b1;
                infl_pc  <= bus.mem_addr;
            end else begin
                infl     <= 1'b0;
            end
        end
    end

    // FIFO storage needs no reset; count gates what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= infl_pc;
            inst_mem[wr_ptr] <= bus.mem_data;
        end
    end

`ifdef FETCH_UNIT_PERF_EN
    logic [32:0] flushed_sum;

    always_comb begin
        flushed_sum = {1'b0, perf_flushed} + 33'(count) + 33'(infl);
    end

    // Both counters saturate rather than wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_delivered <= '0;
            perf_flushed   <= '0;
        end else begin
            if (pop && (perf_delivered != 32'hFFFF_FFFF))
                perf_delivered <= perf_delivered + 32'd1;
            if (bus.redirect)
                perf_flushed <= flushed_sum[32] ? 32'hFFFF_FFFF : flushed_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit; memory model returns {24'h0, addr[7:0]}
// one cycle after each request.
module tb_fetch_unit;
    logic clk;
    logic rst;
    int   checkCount;
    int   passCount;

    fetch_unit_if #(.WIDTH(32)) bus ();

`ifdef FETCH_UNIT_PERF_EN
    logic [31:0] perf_delivered;
    logic [31:0] perf_flushed;
`endif

    fetch_unit #(
        .WIDTH(32),
        .DEPTH(4),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef FETCH_UNIT_PERF_EN
        .perf_delivered(perf_delivered),
        .perf_flushed(perf_flushed),
`endif
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_req) bus.mem_data <= {24'h0, bus.mem_addr[7:0]};
    end

    // Advance one clock, then drive this cycle's inputs and let outputs settle.
    task automatic applyStimulus(input logic r, input logic rdir,
                                 input logic [31:0] raddr, input logic rdy);
        @(posedge clk);
        #1;
        rst               = r;
        bus.redirect      = rdir;
        bus.redirect_addr = raddr;
        bus.out_ready     = rdy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    endtask

    initial begin
        checkCount        = 0;
        passCount         = 0;
        rst               = 1'b1;
        bus.redirect      = 1'b0;
        bus.redirect_addr = '0;
        bus.out_ready     = 1'b0;
        bus.mem_data      = '0;

        // Reset, with a redirect during reset that must be ignored
        applyStimulus(1, 0, 32'h0, 1);
        checkOutput("rst_mem_req", 32'(bus.mem_req), 0);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 0);
        applyStimulus(1, 1, 32'h103, 1);
        checkOutput("rst_misaligned", 32'(bus.redirect_misaligned), 0);
        checkOutput("rst_redir_mem_req", 32'(bus.mem_req), 0);

        // Streaming with out_ready=1
        applyStimulus(0, 0, 32'h0, 1);
        checkOutput("c0_mem_req", 32'(bus.mem_req), 1);
        checkOutput("c0_mem_addr", bus.mem_addr, 32'h0);
        checkOutput("c0_out_valid", 32'(bus.out_valid), 0);
        applyStimulus(0, 0, 32'h0, 1);
        checkOutput("c1_out_valid", 32'(bus.out_valid), 0);
        checkOutput("c1_mem_addr", bus.mem_addr, 32'h4);
        for (int c = 2; c < 9; c++) begin
            applyStimulus(0, 0, 32'h0, 1);
            checkOutput("stream_valid", 32'(bus.out_valid), 1);
            checkOutput("stream_pc", bus.out_pc, 32'((c - 2) * 4));
            checkOutput("stream_inst", bus.out_inst, 32'(((c - 2) * 4) & 8'hFF));
        end

        // Backpressure: out_ready low for 10 cycles, then drain
        applyStimulus(1, 0, 32'h0, 0);
        for (int c = 0; c < 10; c++) begin
            applyStimulus(0, 0, 32'h0, 0);
            checkOutput("bp_mem_req", 32'(bus.mem_req), (c < 4) ? 32'd1 : 32'd0);
            if (c < 4) checkOutput("bp_mem_addr", bus.mem_addr, 32'(c * 4));
        end
        checkOutput("bp_hold_valid", 32'(bus.out_valid), 1);
        checkOutput("bp_hold_pc", bus.out_pc, 32'h0);
        for (int c = 10; c < 16; c++) begin
            applyStimulus(0, 0, 32'h0, 1);
            checkOutput("drain_valid", 32'(bus.out_valid), 1);
            checkOutput("drain_pc", bus.out_pc, 32'((c - 10) * 4));
            if (c == 10) checkOutput("drain_no_lookahead", 32'(bus.mem_req), 0);
            if (c == 11) checkOutput("drain_resume_addr", bus.mem_addr, 32'h10);
        end

        // Redirect with 3 entries queued and one word in flight
        applyStimulus(1, 0, 32'h0, 0);
        for (int c = 0; c < 4; c++) applyStimulus(0, 0, 32'h0, 0);
        applyStimulus(0, 1, 32'h100, 0);
        checkOutput("redir_out_valid", 32'(bus.out_valid), 0);
        checkOutput("redir_mem_req", 32'(bus.mem_req), 1);
        checkOutput("redir_mem_addr", bus.mem_addr, 32'h100);
        checkOutput("redir_misaligned", 32'(bus.redirect_misaligned), 0);
        applyStimulus(0, 0, 32'h0, 1);
        checkOutput("redir_p1_valid", 32'(bus.out_valid), 0);
        checkOutput("redir_p1_addr", bus.mem_addr, 32'h104);
`ifdef FETCH_UNIT_PERF_EN
        checkOutput("perf_flushed_4", perf_flushed, 32'd4);
`endif
        applyStimulus(0, 0, 32'h0, 1);
        checkOutput("redir_p2_pc", bus.out_pc, 32'h100);
        checkOutput("redir_p2_valid", 32'(bus.out_valid), 1);
        applyStimulus(0, 0, 32'h0, 1);
        checkOutput("redir_p3_pc", bus.out_pc, 32'h104);
        checkOutput("redir_p3_inst", bus.out_inst, 32'h04);

        // Misaligned redirect
        applyStimulus(0, 1, 32'h103, 1);
        checkOutput("mis_pulse", 32'(bus.redirect_misaligned), 1);
        checkOutput("mis_mem_addr", bus.mem_addr, 32'h100);
        checkOutput("mis_out_valid", 32'(bus.out_valid), 0);
        applyStimulus(0, 0, 32'h0, 1);
        checkOutput("mis_pulse_end", 32'(bus.redirect_misaligned), 0);
`ifdef FETCH_UNIT_PERF_EN
        checkOutput("perf_delivered_2", perf_delivered, 32'd2);
        checkOutput("perf_flushed_6", perf_flushed, 32'd6);
`endif
        applyStimulus(0, 0, 32'h0, 1);
        checkOutput("mis_pc0", bus.out_pc, 32'h100);
        applyStimulus(0, 0, 32'h0, 1);
        checkOutput("mis_pc1", bus.out_pc, 32'h104);

        // Back-to-back redirects: only the second survives
        applyStimulus(0, 1, 32'h200, 1);
        checkOutput("b2b_addr0", bus.mem_addr, 32'h200);
        applyStimulus(0, 1, 32'h300, 1);
        checkOutput("b2b_addr1", bus.mem_addr, 32'h300);
        checkOutput("b2b_valid1", 32'(bus.out_valid), 0);
        applyStimulus(0, 0, 32'h0, 1);
        checkOutput("b2b_no_stale", 32'(bus.out_valid), 0);
        applyStimulus(0, 0, 32'h0, 1);
        checkOutput("b2b_first_pc", bus.out_pc, 32'h300);
        checkOutput("b2b_first_valid", 32'(bus.out_valid), 1);
        applyStimulus(0, 0, 32'h0, 1);
        checkOutput("b2b_second_pc", bus.out_pc, 32'h304);

        // Reset mid-stream with two entries queued
        applyStimulus(0, 0, 32'h0, 0);
        checkOutput("mid_hold_pc", bus.out_pc, 32'h308);
        applyStimulus(1, 0, 32'h0, 0);
        checkOutput("mid_rst_valid", 32'(bus.out_valid), 0);
        checkOutput("mid_rst_req", 32'(bus.mem_req), 0);
        applyStimulus(0, 0, 32'h0, 1);
        checkOutput("mid_restart_addr", bus.mem_addr, 32'h0);
        checkOutput("mid_restart_valid", 32'(bus.out_valid), 0);
        applyStimulus(0, 0, 32'h0, 1);
        checkOutput("mid_empty", 32'(bus.out_valid), 0);
        applyStimulus(0, 0, 32'h0, 1);
        checkOutput("mid_pc0", bus.out_pc, 32'h0);
        applyStimulus(0, 0, 32'h0, 1);
        checkOutput("mid_pc1", bus.out_pc, 32'h4);

        // PC wraps past the top of the address space
        applyStimulus(0, 1, 32'hFFFF_FFFC, 1);
        checkOutput("wrap_addr", bus.mem_addr, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 32'h0, 1);
        checkOutput("wrap_next_addr", bus.mem_addr, 32'h0);
        applyStimulus(0, 0, 32'h0, 1);
        checkOutput("wrap_pc0", bus.out_pc, 32'hFFFF_FFFC);
        checkOutput("wrap_inst0", bus.out_inst, 32'hFC);
        applyStimulus(0, 0, 32'h0, 1);
        checkOutput("wrap_pc1", bus.out_pc, 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end; feeds the decode/operand-fetch stage of the 4-stage core.
- Owns the fetch PC and issues word reads to the synchronous instruction port of mem_mgr, which has 1-cycle registered read data.
- Buffers returned words with their PCs in a small prefetch FIFO, presented on a valid/ready interface.
- On redirect (taken branch or jump from execute), flushes the FIFO and all in-flight fetches.

Parameters:
- WIDTH, 32: data/address width; must be 32.
- DEPTH, 4: prefetch FIFO entries; power of 2, >=2. DEPTH>=3 is required for 1 inst/cycle throughput.
- RESET_PC, 0: first fetch address after reset; must be word aligned.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_req  out  1  fetch issued this cycle
- mem_addr  out  WIDTH  fetch address (word aligned)
- mem_data  in  WIDTH  read data; valid the cycle after mem_req
- redirect  in  1  flush and restart fetch
- redirect_addr  in  WIDTH  new fetch address
- redirect_misaligned  out  1  1-cycle pulse: redirect_addr[1:0] was nonzero
- out_valid  out  1  out_inst/out_pc valid
- out_ready  in  1  downstream accepts
- out_inst  out  WIDTH  instruction word
- out_pc  out  WIDTH  address of out_inst

Behaviour:
- Clock clk; reset rst, synchronous, active-high.
- During the rst cycle:
  - Outputs are 0: mem_req, out_valid, redirect_misaligned.
  - FIFO is emptied; in-flight flag is cleared; fetch_pc <= RESET_PC.
  - out_inst, out_pc and mem_addr are don't-care while their qualifier is 0.
- State:
  - fetch_pc
  - FIFO: DEPTH entries of {pc, inst}, rd/wr pointers of log2(DEPTH) bits plus a count of log2(DEPTH)+1 bits
  - infl: 1-bit in-flight flag
  - infl_pc
- Issue rule:
  - mem_req = !rst && (redirect || (count + infl) < DEPTH).
  - Credits are checked without pop look-ahead, so FIFO overflow is impossible.
- Normal issue:
  - mem_addr = fetch_pc.
  - On issue: fetch_pc <= fetch_pc+4; infl <= 1; infl_pc <= mem_addr. Otherwise infl <= 0.
- Response:
  - If infl was set and was not killed, push {infl_pc, mem_data} into the FIFO at the end of that cycle.
  - Latency: request in cycle N gives out_valid in cycle N+2 (FIFO empty case).
- Output:
  - out_valid = count != 0 && !redirect.
  - out_inst/out_pc come from the FIFO head, registered storage, with no combinational path from mem_data.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle leave count unchanged.
- Redirect cycle:
  - FIFO is flushed; count <= 0; no pop, so out_ready is ignored.
  - Any response arriving this cycle is discarded.
  - mem_req = 1 and mem_addr = {redirect_addr[WIDTH-1:2], 2'b00}.
  - fetch_pc <= aligned redirect_addr + 4; infl <= 1 (new request, not killed).
  - redirect_misaligned = |redirect_addr[1:0], combinational, in the same cycle.
- Back-to-back redirects: each one restarts fetch. Only the last one's fetches survive.
- PC arithmetic wraps modulo 2^WIDTH: 0xFFFFFFFC + 4 = 0x00000000.
- Redirect during rst is ignored; rst has priority.

Optional Feature:
- Macro: FETCH_UNIT_PERF_EN.
- Defined: adds output ports perf_delivered (32 bits) and perf_flushed (32 bits), reset to 0, saturating at 0xFFFFFFFF.
  - perf_delivered increments by 1 on each pop.
  - perf_flushed increments on each redirect by count + (infl ? 1 : 0), the entries and responses discarded.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then out_ready=1 with mem returning the word 0x000000{addr[7:0]}:
  - first mem_req has addr 0x0 in cycle 0 after reset;
  - out_valid first rises in cycle 2 with out_pc=0x0;
  - afterwards one instruction per cycle with pc 0x4, 0x8, ... and no gaps.
- out_ready=0 for 10 cycles:
  - mem_req stops after exactly DEPTH=4 outstanding words (count + infl = 4);
  - on releasing out_ready, pcs 0x0..0xC drain in order and fetch resumes at 0x10 with no loss or duplicate.
- FIFO holds 3 entries, infl=1, then redirect with redirect_addr=0x100:
  - out_valid=0 that cycle and the stale response is dropped;
  - next delivered pc=0x100 in cycle +2, then 0x104;
  - with FETCH_UNIT_PERF_EN, perf_flushed += 4.
- redirect_addr=0x103:
  - redirect_misaligned pulses for 1 cycle;
  - mem_addr=0x100; delivered pcs are 0x100, 0x104.
- Redirects to 0x200 and then 0x300 in consecutive cycles: no pc 0x200 or 0x204 is ever delivered; the first delivered pc is 0x300.
- rst asserted mid-stream with 2 entries queued: the next cycle has out_valid=0 and mem_req=0; after deassert, fetch restarts at RESET_PC.
